// File: rtl/alu_arbiter_if.sv
// Request, ALU and response signals of the two-requester ALU arbiter.
// The slave modport is the arbiter; the master modport is the requesters, ALU and consumer.
interface alu_arbiter_if #(
  parameter int unsigned LENGTH = 64
);
  logic              req0_valid;
  logic              req0_ready;
  logic [LENGTH-1:0] req0_A;
  logic [LENGTH-1:0] req0_B;
  logic [2:0]        req0_sel;
  logic              req0_setflags;

  logic              req1_valid;
  logic              req1_ready;
  logic [LENGTH-1:0] req1_A;
  logic [LENGTH-1:0] req1_B;
  logic [2:0]        req1_sel;
  logic              req1_setflags;

  logic [LENGTH-1:0] alu_A;
  logic [LENGTH-1:0] alu_B;
  logic [2:0]        alu_select;
  logic [LENGTH-1:0] alu_result;
  logic              alu_negative;
  logic              alu_zero;
  logic              alu_overflow;
  logic              alu_carry;

  logic              resp_valid;
  logic              resp_ready;
  logic              resp_id;
  logic [LENGTH-1:0] resp_result;
  logic [3:0]        flags;

  modport slave (
    input  req0_valid, req0_A, req0_B, req0_sel, req0_setflags,
    input  req1_valid, req1_A, req1_B, req1_sel, req1_setflags,
    input  alu_result, alu_negative, alu_zero, alu_overflow, alu_carry,
    input  resp_ready,
    output req0_ready, req1_ready,
    output alu_A, alu_B, alu_select,
    output resp_valid, resp_id, resp_result, flags
  );

  modport master (
    output req0_valid, req0_A, req0_B, req0_sel, req0_setflags,
    output req1_valid, req1_A, req1_B, req1_sel, req1_setflags,
    output alu_result, alu_negative, alu_zero, alu_overflow, alu_carry,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  alu_A, alu_B, alu_select,
    input  resp_valid, resp_id, resp_result, flags
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one multi-cycle ALU between two requesters, with a held response
// register and the architectural NZVC flag register.
module alu_arbiter #(
  parameter int unsigned LENGTH        = 64,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);
  localparam int unsigned      CntW    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CntW-1:0]  CntLast = CntW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              id_q, id_d;
  logic              setflags_q, setflags_d;
  logic [LENGTH-1:0] alu_a_q, alu_a_d;
  logic [LENGTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]        alu_select_q, alu_select_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_id_q, resp_id_d;
  logic [LENGTH-1:0] resp_result_q, resp_result_d;
  logic [3:0]        flags_q, flags_d;
  logic              grant0, grant1;
  logic              hs0, hs1;

  // On a tie the requester that did not win last goes; rr_last resets to 1 so req0 wins first.
  assign grant0 = bus.req0_valid & (~bus.req1_valid | rr_last_q);
  assign grant1 = bus.req1_valid & (~bus.req0_valid | ~rr_last_q);
  assign hs0    = (state_q == StIdle) & ~reset & grant0;
  assign hs1    = (state_q == StIdle) & ~reset & grant1;

  assign bus.req0_ready  = hs0;
  assign bus.req1_ready  = hs1;
  assign bus.alu_A       = alu_a_q;
  assign bus.alu_B       = alu_b_q;
  assign bus.alu_select  = alu_select_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_result = resp_result_q;
  assign bus.flags       = flags_q;

  always_comb begin
    state_d       = state_q;
    rr_last_d     = rr_last_q;
    cnt_d         = cnt_q;
    id_d          = id_q;
    setflags_d    = setflags_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_select_d  = alu_select_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    flags_d       = flags_q;
    unique case (state_q)
      StIdle: begin
        if (hs0 | hs1) begin
          alu_a_d      = hs1 ? bus.req1_A : bus.req0_A;
          alu_b_d      = hs1 ? bus.req1_B : bus.req0_B;
          alu_select_d = hs1 ? bus.req1_sel : bus.req0_sel;
          setflags_d   = hs1 ? bus.req1_setflags : bus.req0_setflags;
          id_d         = hs1;
          rr_last_d    = hs1;
          cnt_d        = '0;
          state_d      = StBusy;
        end
      end
      StBusy: begin
        // Operands have been held for SETTLE_CYCLES edges; the ALU output is now trustworthy.
        if (cnt_q == CntLast) begin
          resp_result_d = bus.alu_result;
          resp_id_d     = id_q;
          resp_valid_d  = 1'b1;
          if (setflags_q) begin
            flags_d = {bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_carry};
          end
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      rr_last_q     <= 1'b1;
      cnt_q         <= '0;
      id_q          <= 1'b0;
      setflags_q    <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_select_q  <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
      flags_q       <= 4'b0000;
    end else begin
      state_q       <= state_d;
      rr_last_q     <= rr_last_d;
      cnt_q         <= cnt_d;
      id_q          <= id_d;
      setflags_q    <= setflags_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_select_q  <= alu_select_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      flags_q       <= flags_d;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a transaction-level model checks a SETTLE_CYCLES=1 instance every cycle,
// while directed cases pin literal results, and a SETTLE_CYCLES=3 instance checks capture timing.
module tb_alu_arbiter;
  localparam int unsigned W  = 64;
  localparam int          S1 = 1;
  localparam logic [67:0] Junk = {64'hA5A5_5A5A_DEAD_BEEF, 4'hF};

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  alu_arbiter_if #(.LENGTH(W)) bus1 ();
  alu_arbiter_if #(.LENGTH(W)) bus3 ();

  alu_arbiter #(.LENGTH(W), .SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
  alu_arbiter #(.LENGTH(W), .SETTLE_CYCLES(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

  always #5 clk = ~clk;

  // Reference ALU: {result, N, Z, V, C}; carry on subtract means "no borrow".
  function automatic logic [67:0] alu_fn(input logic [63:0] a, input logic [63:0] b,
                                         input logic [2:0] sel);
    logic [64:0] wide;
    logic [63:0] r;
    logic        v, c;
    wide = '0;
    r    = '0;
    v    = 1'b0;
    c    = 1'b0;
    case (sel)
      3'b000: r = b;
      3'b010: begin
        wide = {1'b0, a} + {1'b0, b};
        r    = wide[63:0];
        c    = wide[64];
        v    = (a[63] == b[63]) && (r[63] != a[63]);
      end
      3'b011: begin
        wide = {1'b0, a} + {1'b0, ~b} + 65'd1;
        r    = wide[63:0];
        c    = wide[64];
        v    = (a[63] != b[63]) && (r[63] != a[63]);
      end
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = a ^ b;
      default: r = '0;
    endcase
    return {r, r[63], (r == 64'd0), v, c};
  endfunction

  assign {bus1.alu_result, bus1.alu_negative, bus1.alu_zero, bus1.alu_overflow,
          bus1.alu_carry} = alu_fn(bus1.alu_A, bus1.alu_B, bus1.alu_select);

  // Slow ALU for the 3-cycle instance: garbage until operands have been stable for 3 cycles.
  logic [130:0] last3 = '0;
  int           age3 = 0;
  always @(negedge clk) begin
    if ({bus3.alu_A, bus3.alu_B, bus3.alu_select} == last3) begin
      if (age3 < 15) age3 <= age3 + 1;
    end else begin
      age3 <= 0;
    end
    last3 <= {bus3.alu_A, bus3.alu_B, bus3.alu_select};
  end
  assign {bus3.alu_result, bus3.alu_negative, bus3.alu_zero, bus3.alu_overflow,
          bus3.alu_carry} = alu_fn(bus3.alu_A, bus3.alu_B, bus3.alu_select)
                            ^ ((age3 >= 2) ? 68'd0 : Junk);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Winner of the current request pattern: -1 none, else requester index.
  function automatic int pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return last ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // Transaction-level model of bus1: one op in flight, response visible S1+1 cycles after accept.
  logic        m_pending, m_rr, m_op_id, m_op_sf, m_id;
  int          m_age, m_win;
  logic [63:0] m_res, m_alu_a, m_alu_b;
  logic [2:0]  m_alu_sel;
  logic [3:0]  m_flags;
  logic [67:0] m_out;

  always_comb m_win = pick(bus1.req0_valid, bus1.req1_valid, m_rr);
  assign m_out = alu_fn(m_alu_a, m_alu_b, m_alu_sel);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pending <= 1'b0;
      m_rr      <= 1'b1;
      m_age     <= 0;
      m_op_id   <= 1'b0;
      m_op_sf   <= 1'b0;
      m_id      <= 1'b0;
      m_res     <= '0;
      m_alu_a   <= '0;
      m_alu_b   <= '0;
      m_alu_sel <= '0;
      m_flags   <= '0;
    end else if (m_pending) begin
      if (m_age >= S1 + 1) begin
        if (bus1.resp_ready) m_pending <= 1'b0;
      end else begin
        if (m_age == S1) begin
          m_res <= m_out[67:4];
          m_id  <= m_op_id;
          if (m_op_sf) m_flags <= m_out[3:0];
        end
        m_age <= m_age + 1;
      end
    end else if (m_win >= 0) begin
      m_pending <= 1'b1;
      m_age     <= 1;
      m_rr      <= (m_win == 1);
      m_op_id   <= (m_win == 1);
      m_op_sf   <= (m_win == 1) ? bus1.req1_setflags : bus1.req0_setflags;
      m_alu_a   <= (m_win == 1) ? bus1.req1_A : bus1.req0_A;
      m_alu_b   <= (m_win == 1) ? bus1.req1_B : bus1.req0_B;
      m_alu_sel <= (m_win == 1) ? bus1.req1_sel : bus1.req0_sel;
    end
  end

  always @(negedge clk) begin
    chk("m_ready0", 64'(bus1.req0_ready), 64'(!reset && !m_pending && m_win == 0));
    chk("m_ready1", 64'(bus1.req1_ready), 64'(!reset && !m_pending && m_win == 1));
    chk("m_resp_valid", 64'(bus1.resp_valid), 64'(m_pending && m_age >= S1 + 1));
    chk("m_resp_id", 64'(bus1.resp_id), 64'(m_id));
    chk("m_resp_result", bus1.resp_result, m_res);
    chk("m_flags", 64'(bus1.flags), 64'(m_flags));
    chk("m_alu_A", bus1.alu_A, m_alu_a);
    chk("m_alu_B", bus1.alu_B, m_alu_b);
    chk("m_alu_select", 64'(bus1.alu_select), 64'(m_alu_sel));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input int n, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] sel, input logic sf);
    if (n == 0) begin
      bus1.req0_valid = 1'b1; bus1.req0_A = a; bus1.req0_B = b;
      bus1.req0_sel = sel; bus1.req0_setflags = sf;
    end else begin
      bus1.req1_valid = 1'b1; bus1.req1_A = a; bus1.req1_B = b;
      bus1.req1_sel = sel; bus1.req1_setflags = sf;
    end
  endtask

  // Called in the first BUSY cycle; ends at the start of the following IDLE cycle.
  task automatic complete(input string tag, input logic id, input logic [63:0] res);
    step();
    @(negedge clk);
    chk({tag, "_valid"}, 64'(bus1.resp_valid), 64'd1);
    chk({tag, "_id"}, 64'(bus1.resp_id), 64'(id));
    chk({tag, "_result"}, bus1.resp_result, res);
    bus1.resp_ready = 1'b1;
    step();
    bus1.resp_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 4))
      0: return 64'd0;
      1: return {64{1'b1}};
      2: return 64'h8000_0000_0000_0000 | 64'($urandom_range(0, 3));
      3: return 64'($urandom_range(0, 15));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [2:0] sels [6];
    sels = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
    reset = 1'b1;
    {bus1.req0_valid, bus1.req0_A, bus1.req0_B, bus1.req0_sel, bus1.req0_setflags} = '0;
    {bus1.req1_valid, bus1.req1_A, bus1.req1_B, bus1.req1_sel, bus1.req1_setflags} = '0;
    {bus3.req0_valid, bus3.req0_A, bus3.req0_B, bus3.req0_sel, bus3.req0_setflags} = '0;
    {bus3.req1_valid, bus3.req1_A, bus3.req1_B, bus3.req1_sel, bus3.req1_setflags} = '0;
    bus1.resp_ready = 1'b0;
    bus3.resp_ready = 1'b0;
    step();
    step();

    // Reset values, with req0 already requesting: ready must stay low while reset is high.
    drive1(0, 64'd4, 64'd3, 3'b010, 1'b1);
    @(negedge clk);
    chk("rst_ready0", 64'(bus1.req0_ready), 64'd0);
    chk("rst_resp_valid", 64'(bus1.resp_valid), 64'd0);
    chk("rst_flags", 64'(bus1.flags), 64'd0);
    chk("rst_alu_A", bus1.alu_A, 64'd0);
    chk("rst_resp_result", bus1.resp_result, 64'd0);
    step();
    reset = 1'b0;

    // 4 + 3 accepted in cycle 0, response in cycle 2.
    @(negedge clk);
    chk("t1_ready0", 64'(bus1.req0_ready), 64'd1);
    step();
    bus1.req0_valid = 1'b0;
    @(negedge clk);
    chk("t1_busy_resp_valid", 64'(bus1.resp_valid), 64'd0);
    chk("t1_alu_A", bus1.alu_A, 64'd4);
    complete("t1", 1'b0, 64'd7);
    @(negedge clk);
    chk("t1_flags", 64'(bus1.flags), 64'd0);
    chk("t1_released", 64'(bus1.resp_valid), 64'd0);
    step();

    // Round-robin from reset: req0, then req1, then req0 again.
    do_reset();
    drive1(0, 64'd1, 64'd2, 3'b010, 1'b0);
    drive1(1, 64'd5, 64'd6, 3'b100, 1'b0);
    @(negedge clk);
    chk("t2_tie_ready0", 64'(bus1.req0_ready), 64'd1);
    chk("t2_tie_ready1", 64'(bus1.req1_ready), 64'd0);
    step();
    bus1.req0_valid = 1'b0;
    complete("t2a", 1'b0, 64'd3);
    @(negedge clk);
    chk("t2_second_ready1", 64'(bus1.req1_ready), 64'd1);
    step();
    bus1.req1_valid = 1'b0;
    complete("t2b", 1'b1, 64'd4);
    drive1(0, 64'd7, 64'd1, 3'b011, 1'b0);
    drive1(1, 64'd8, 64'd8, 3'b110, 1'b0);
    @(negedge clk);
    chk("t2_alt_ready0", 64'(bus1.req0_ready), 64'd1);
    chk("t2_alt_ready1", 64'(bus1.req1_ready), 64'd0);
    step();
    bus1.req0_valid = 1'b0;
    bus1.req1_valid = 1'b0;
    complete("t2c", 1'b0, 64'd6);

    // 3 - 3 sets Z and C; a following non-flag pass-B leaves them alone.
    drive1(1, 64'd3, 64'd3, 3'b011, 1'b1);
    @(negedge clk);
    chk("t3_ready1", 64'(bus1.req1_ready), 64'd1);
    step();
    bus1.req1_valid = 1'b0;
    complete("t3_sub", 1'b1, 64'd0);
    drive1(0, 64'd123, 64'd9, 3'b000, 1'b0);
    @(negedge clk);
    chk("t3_flags_zc", 64'(bus1.flags), 64'b0101);
    step();
    bus1.req0_valid = 1'b0;
    complete("t3_pass", 1'b0, 64'd9);
    @(negedge clk);
    chk("t3_flags_kept", 64'(bus1.flags), 64'b0101);
    step();

    // Back-pressure: response held five cycles with both requesters waiting.
    drive1(0, 64'd100, 64'd23, 3'b010, 1'b0);
    drive1(1, 64'd1, 64'd1, 3'b010, 1'b0);
    @(negedge clk);
    chk("t4_ready1", 64'(bus1.req1_ready), 64'd1);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", 64'(bus1.resp_valid), 64'd1);
      chk("t4_hold_result", bus1.resp_result, 64'd2);
      chk("t4_hold_id", 64'(bus1.resp_id), 64'd1);
      chk("t4_hold_ready0", 64'(bus1.req0_ready), 64'd0);
      chk("t4_hold_ready1", 64'(bus1.req1_ready), 64'd0);
      step();
    end
    bus1.resp_ready = 1'b1;
    step();
    bus1.resp_ready = 1'b0;
    @(negedge clk);
    chk("t4_idle_ready0", 64'(bus1.req0_ready), 64'd1);
    step();
    bus1.req0_valid = 1'b0;
    bus1.req1_valid = 1'b0;
    complete("t4_next", 1'b0, 64'd123);

    // Reset in the middle of a flag-setting op drops it completely.
    drive1(0, 64'd5, 64'd5, 3'b011, 1'b1);
    step();
    reset = 1'b1;
    bus1.req0_valid = 1'b1;
    #1;
    chk("t6_resp_valid", 64'(bus1.resp_valid), 64'd0);
    chk("t6_flags", 64'(bus1.flags), 64'd0);
    chk("t6_alu_A", bus1.alu_A, 64'd0);
    chk("t6_ready0", 64'(bus1.req0_ready), 64'd0);
    step();
    reset = 1'b0;
    bus1.req0_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_no_resp", 64'(bus1.resp_valid), 64'd0);
      step();
    end

    // Three settle cycles: operands held, result captured only after the slow ALU settles.
    bus3.req0_valid = 1'b1; bus3.req0_A = 64'd10; bus3.req0_B = 64'd5;
    bus3.req0_sel = 3'b011; bus3.req0_setflags = 1'b1;
    @(negedge clk);
    chk("t5_ready0", 64'(bus3.req0_ready), 64'd1);
    step();
    bus3.req0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_alu_A", bus3.alu_A, 64'd10);
      chk("t5_alu_B", bus3.alu_B, 64'd5);
      chk("t5_alu_select", 64'(bus3.alu_select), 64'd3);
      chk("t5_early_valid", 64'(bus3.resp_valid), 64'd0);
      step();
    end
    @(negedge clk);
    chk("t5_resp_valid", 64'(bus3.resp_valid), 64'd1);
    chk("t5_resp_result", bus3.resp_result, 64'd5);
    chk("t5_flags", 64'(bus3.flags), 64'b0001);
    bus3.resp_ready = 1'b1;
    step();
    bus3.resp_ready = 1'b0;
    @(negedge clk);
    chk("t5_done", 64'(bus3.resp_valid), 64'd0);
    step();

    // Random traffic on the single-settle instance, checked by the model.
    for (int c = 0; c < 3000; c++) begin
      bus1.req0_valid    = ($urandom_range(0, 9) < 6);
      bus1.req0_A        = rand64();
      bus1.req0_B        = rand64();
      bus1.req0_sel      = sels[$urandom_range(0, 5)];
      bus1.req0_setflags = $urandom_range(0, 1) == 1;
      bus1.req1_valid    = ($urandom_range(0, 9) < 6);
      bus1.req1_A        = rand64();
      bus1.req1_B        = rand64();
      bus1.req1_sel      = sels[$urandom_range(0, 5)];
      bus1.req1_setflags = $urandom_range(0, 1) == 1;
      bus1.resp_ready    = ($urandom_range(0, 9) < 7);
      reset              = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    bus1.req0_valid = 1'b0;
    bus1.req1_valid = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
